// File: rtl/bidir_bus_ctrl.sv
// bidir_bus_ctrl: direction controller for a shared WIDTH-bit bus.
// Ports: clk/rst (sync, active-high); io shared bus; tx_data/tx_valid/
//   tx_ready transmit handshake; rx_en receive request; rx_data/rx_valid/
//   rx_change synchronised receive path; oe registered enable; err sticky
//   contention flag.
module bidir_bus_ctrl #(
   parameter int WIDTH       = 8,
   parameter int TURN_CYC    = 2,
   parameter int HOLD_CYC    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   inout  wire  [WIDTH-1:0] io,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic             rx_en,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             rx_change,
   output logic             oe,
   output logic             err
);

   localparam int M1 = (TURN_CYC > HOLD_CYC) ? TURN_CYC : HOLD_CYC;
   localparam int CMAX = (M1 > SYNC_STAGES) ? M1 : SYNC_STAGES;
   localparam int CW = $clog2(CMAX + 1);
   localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYC - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] SYNC_FULL = CW'(SYNC_STAGES);

   typedef enum logic [1:0] {
      HIZ,
      PRE_DRV,
      DRIVE,
      POST_DRV
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_turn;
   logic [CW-1:0]    r_idle;
   logic [CW-1:0]    r_word;
   logic [CW-1:0]    r_samp;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   logic             r_oe;
   logic             r_err;
   logic             r_prev_ok;
   logic             w_hs;
   logic             w_idle_done;

   assign io      = r_oe ? r_out : {WIDTH{1'bz}};
   assign oe      = r_oe;
   assign err     = r_err;
   assign rx_data = r_sync[SYNC_STAGES-1];

   assign w_hs        = (r_state == DRIVE) && tx_valid && !rx_en;
   // the idle count reaches HOLD_CYC at this edge
   assign w_idle_done = !w_hs && (r_idle == HOLD_LAST);

   always_ff @(posedge clk) begin
      if (rst) r_state <= HIZ;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         HIZ: begin
            if (tx_valid && !rx_en) w_next = PRE_DRV;
         end
         PRE_DRV: begin
            if (rx_en)                     w_next = HIZ;
            else if (r_turn == TURN_LAST)  w_next = DRIVE;
         end
         DRIVE: begin
            if (rx_en || w_idle_done) w_next = POST_DRV;
         end
         POST_DRV: begin
            if (r_turn == TURN_LAST) w_next = HIZ;
         end
         default: w_next = HIZ;
      endcase
   end

   always_comb begin
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      unique case (r_state)
         DRIVE:   tx_ready = !rx_en;
         HIZ:     rx_valid = rx_en && (r_samp == SYNC_FULL);
         default: ;
      endcase
      rx_change = rx_valid && r_prev_ok && (rx_data != r_prev);
   end

   // turnaround counter restarts on every state change
   always_ff @(posedge clk) begin
      if (rst || (w_next != r_state))  r_turn <= '0;
      else if (r_turn != TURN_LAST)    r_turn <= r_turn + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || (r_state != DRIVE) || w_hs) r_idle <= '0;
      else if (r_idle != HOLD_LAST)          r_idle <= r_idle + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_oe  <= 1'b0;
         r_out <= '0;
      end else begin
         if (w_next != DRIVE) r_oe <= 1'b0;
         else if (w_hs)       r_oe <= 1'b1;
         if (w_hs) r_out <= tx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= io;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   // own word must have crossed the synchroniser before it is compared
   always_ff @(posedge clk) begin
      if (rst || (r_state != DRIVE) || w_hs)  r_word <= '0;
      else if (r_oe && (r_word != SYNC_FULL)) r_word <= r_word + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if ((r_state == DRIVE) && r_oe && (r_word == SYNC_FULL)
                   && (rx_data !== r_out)) begin
         r_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || (r_state != HIZ)) r_samp <= '0;
      else if (r_samp != SYNC_FULL) r_samp <= r_samp + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev    <= '0;
         r_prev_ok <= 1'b0;
      end else if (r_state != HIZ) begin
         r_prev_ok <= 1'b0;
      end else if (rx_valid) begin
         r_prev    <= rx_data;
         r_prev_ok <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// tb_bidir_bus_ctrl: directed scenarios plus random traffic, all
// cycles compared against a transaction-level model of the controller.
module tb_bidir_bus_ctrl;

   localparam int TURN = 2;
   localparam int HOLD = 4;
   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_valid;
   logic       rx_en;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       rx_valid;
   logic       rx_change;
   logic       oe;
   logic       err;
   logic [7:0] rx_data;
   wire  [7:0] io_w;
   logic       r_rem_en;
   logic [7:0] r_rem;

   always #5 clk = ~clk;

   assign io_w = r_rem_en ? r_rem : 8'bz;

   bidir_bus_ctrl #(
      .WIDTH(8), .TURN_CYC(TURN), .HOLD_CYC(HOLD), .SYNC_STAGES(SYNC)
   ) dut (
      .clk(clk), .rst(rst), .io(io_w),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_en(rx_en), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_change(rx_change), .oe(oe), .err(err)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // model: countdowns for the turnaround windows, a bus history
   // queue for the receive delay
   bit         m_ok;
   bit         m_oe;
   bit         m_err;
   bit         m_drv;
   bit         m_have;
   logic [7:0] m_out;
   logic [7:0] m_prev;
   int         m_pre;
   int         m_post;
   int         m_idle;
   int         m_since;
   int         m_age;
   logic [7:0] m_line[$];
   bit         m_known[$];

   function automatic void model_reset();
      m_oe = 0; m_err = 0; m_drv = 0; m_have = 0;
      m_out = 0; m_prev = 0;
      m_pre = 0; m_post = 0; m_idle = 0; m_since = 0; m_age = 0;
      m_line = {};
      m_known = {};
      for (int i = 0; i < SYNC; i++) begin
         m_line.push_back(8'h00);
         m_known.push_back(1'b1);
      end
   endfunction

   function automatic bit m_hiz();
      return !m_drv && (m_pre == 0) && (m_post == 0);
   endfunction

   function automatic void enter_hiz();
      m_age  = 0;
      m_have = 0;
   endfunction

   function automatic void model_edge(input bit tv, input logic [7:0] td,
                                      input bit rx, input bit ren,
                                      input logic [7:0] rem);
      logic [7:0] bus;
      logic [7:0] rxd;
      bit kn;
      bit rxv;
      bit nerr;
      bit hs;
      rxd  = m_line[0];
      rxv  = m_hiz() && rx && (m_age >= SYNC);
      nerr = m_drv && m_oe && (m_since >= SYNC) && (rxd != m_out);
      bus  = m_oe ? (m_out | (ren ? rem : 8'h00)) : (ren ? rem : 8'h00);
      kn   = (m_oe != ren);
      if (m_hiz()) begin
         if (rxv) begin
            m_prev = rxd;
            m_have = 1;
         end
         if (m_age < SYNC) m_age++;
         if (tv && !rx) m_pre = TURN;
      end else if (m_pre > 0) begin
         if (rx) begin
            m_pre = 0;
            enter_hiz();
         end else begin
            m_pre--;
            if (m_pre == 0) begin
               m_drv = 1; m_idle = 0; m_since = 0;
            end
         end
      end else if (m_drv) begin
         hs = tv && !rx;
         if (hs) begin
            m_out = td; m_oe = 1; m_idle = 0; m_since = 0;
         end else begin
            m_idle++;
            if (m_oe) m_since++;
         end
         if (rx || (m_idle == HOLD)) begin
            m_drv = 0; m_oe = 0; m_post = TURN;
         end
      end else begin
         m_post--;
         if (m_post == 0) enter_hiz();
      end
      if (nerr) m_err = 1;
      m_line.push_back(bus);
      m_known.push_back(kn);
      void'(m_line.pop_front());
      void'(m_known.pop_front());
   endfunction

   logic       o_rdy;
   logic       o_oe;
   logic       o_err;
   logic       o_rxv;
   logic       o_chg;
   logic [7:0] o_io;
   logic [7:0] o_rxd;

   // one clock cycle: drive, compare against model, clock the model
   task automatic step(input bit r, input bit tv, input logic [7:0] td,
                       input bit rx, input bit frc, input logic [7:0] rem);
      bit e_rdy;
      bit e_rxv;
      bit e_chg;
      logic [7:0] e_rxd;
      rst = r; tx_valid = tv; tx_data = td; rx_en = rx;
      r_rem = rem;
      r_rem_en = frc || !m_oe;
      #1;
      o_rdy = tx_ready; o_oe = oe; o_err = err; o_rxv = rx_valid;
      o_chg = rx_change; o_io = io_w; o_rxd = rx_data;
      if (m_ok) begin
         e_rdy = m_drv && !rx;
         e_rxv = m_hiz() && rx && (m_age >= SYNC);
         e_rxd = m_line[0];
         e_chg = e_rxv && m_have && (e_rxd != m_prev);
         chk("tx_ready", 32'(o_rdy), 32'(e_rdy));
         chk("oe", 32'(o_oe), 32'(m_oe));
         chk("err", 32'(o_err), 32'(m_err));
         chk("rx_valid", 32'(o_rxv), 32'(e_rxv));
         if (m_known[0]) begin
            chk("rx_data", 32'(o_rxd), 32'(e_rxd));
            chk("rx_change", 32'(o_chg), 32'(e_chg));
         end
         if (m_oe && !frc) chk("io", 32'(o_io), 32'(m_out));
      end
      @(posedge clk);
      if (r) begin
         model_reset();
         m_ok = 1;
      end else if (m_ok) begin
         model_edge(tv, td, rx, r_rem_en, rem);
      end
      #1;
   endtask

   task automatic wait_ready(input logic [7:0] d);
      for (int i = 0; i < 8; i++) begin
         step(0, 1, d, 0, 0, 8'($urandom));
         if (o_rdy) return;
      end
      chk("ready_wait", 32'(o_rdy), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] w [4];
      int k;
      int oe_seen;
      bit rxr;
      int pct;
      w[0] = 8'h01; w[1] = 8'h02; w[2] = 8'h03; w[3] = 8'h04;
      model_reset();
      m_ok = 0;
      rst = 1; tx_valid = 0; tx_data = 0; rx_en = 0;
      r_rem = 8'hA5; r_rem_en = 1;

      // reset, then receive with remote driving A5
      step(1, 0, 0, 1, 0, 8'hA5);
      step(1, 0, 0, 1, 0, 8'hA5);
      chk("rst_oe", 32'(o_oe), 32'd0);
      chk("rst_rdy", 32'(o_rdy), 32'd0);
      chk("rst_err", 32'(o_err), 32'd0);
      chk("rst_rxd", 32'(o_rxd), 32'd0);
      chk("rst_rxv", 32'(o_rxv), 32'd0);
      oe_seen = 0;
      step(0, 0, 0, 1, 0, 8'hA5);
      oe_seen += int'(o_oe);
      step(0, 0, 0, 1, 0, 8'hA5);
      oe_seen += int'(o_oe);
      chk("rxv_early", 32'(o_rxv), 32'd0);
      step(0, 0, 0, 1, 0, 8'hA5);
      oe_seen += int'(o_oe);
      chk("rxv_2cyc", 32'(o_rxv), 32'd1);
      chk("rxd_a5", 32'(o_rxd), 32'hA5);
      chk("no_chg", 32'(o_chg), 32'd0);
      chk("rx_oe_off", 32'(oe_seen), 32'd0);
      repeat (2) step(0, 0, 0, 1, 0, 8'h5A);
      repeat (3) step(0, 0, 0, 1, 0, 8'h5A);

      // single transmit
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 8'h3C, 0, 0, 8'($urandom));
         chk("tx_wait", 32'(o_rdy), 32'd0);
      end
      step(0, 1, 8'h3C, 0, 0, 8'($urandom));
      chk("tx_rdy_e3", 32'(o_rdy), 32'd1);
      step(0, 0, 0, 0, 0, 8'($urandom));
      chk("tx_oe", 32'(o_oe), 32'd1);
      chk("tx_io", 32'(o_io), 32'h3C);
      k = 1;
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 0, 0, 0, 8'($urandom));
         if (!o_oe) break;
         k++;
      end
      chk("hold_cyc", 32'(k), 32'd4);
      repeat (2) step(0, 0, 0, 0, 0, 8'($urandom));

      // burst of four words
      wait_ready(w[0]);
      for (int j = 1; j < 4; j++) begin
         step(0, 1, w[j], 0, 0, 8'($urandom));
         chk("burst_io", 32'(o_io), 32'(w[j-1]));
      end
      step(0, 0, 0, 0, 0, 8'($urandom));
      chk("burst_io", 32'(o_io), 32'(w[3]));
      chk("burst_err", 32'(o_err), 32'd0);

      // receive request pre-empts drive
      step(0, 1, 8'h55, 1, 0, 8'($urandom));
      chk("pre_rdy", 32'(o_rdy), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 1, 0, 8'h99);
         if (i == 0) chk("pre_oe", 32'(o_oe), 32'd0);
         chk("pre_rxv", 32'(o_rxv), 32'd0);
      end
      step(0, 0, 0, 1, 0, 8'h99);
      chk("rx_back", 32'(o_rxv), 32'd1);
      repeat (3) step(0, 0, 0, 1, 0, 8'($urandom));

      // contention while driving 00
      wait_ready(8'h00);
      repeat (4) step(0, 0, 0, 0, 1, 8'hFF);
      chk("cont_err", 32'(o_err), 32'd1);
      repeat (6) step(0, 0, 0, 0, 0, 8'($urandom));
      chk("err_sticky", 32'(o_err), 32'd1);
      step(1, 0, 0, 0, 0, 8'($urandom));
      step(0, 0, 0, 0, 0, 8'($urandom));
      chk("err_clr", 32'(o_err), 32'd0);

      // reset in the middle of a burst
      wait_ready(8'($urandom));
      repeat (2) step(0, 1, 8'($urandom), 0, 0, 8'($urandom));
      step(1, 1, 8'($urandom), 0, 0, 8'($urandom));
      step(0, 1, 8'($urandom), 0, 0, 8'($urandom));
      chk("mid_oe", 32'(o_oe), 32'd0);
      chk("mid_rdy", 32'(o_rdy), 32'd0);
      chk("mid_err", 32'(o_err), 32'd0);

      // random traffic
      rxr = 0;
      pct = 50;
      for (int c = 0; c < 1500; c++) begin
         if (c % 64 == 0) pct = int'($urandom_range(0, 3)) * 33;
         if ($urandom_range(0, 9) == 0) rxr = !rxr;
         step($urandom_range(0, 199) == 0,
              int'($urandom_range(0, 99)) < pct,
              8'($urandom), rxr, 0, 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
